vadd_issue_seq: RTL

//  Sequences one vector add/min/max/compare/avg instruction into per-beat requests for the vAdd

---
 rtl/vadd_issue_seq_pkg.sv | 31 +++
 rtl/vadd_tail_be.sv | 25 ++
 rtl/vadd_issue_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vadd_issue_seq_pkg.sv
// Shared constants, encodings and FSM states for the vAdd issue sequencer.
package vadd_issue_seq_pkg;

  localparam int unsigned DATA_WIDTH      = 64;
  localparam int unsigned BE_WIDTH        = DATA_WIDTH / 8;
  localparam int unsigned BE_IDX_WIDTH    = $clog2(BE_WIDTH);
  localparam int unsigned EPB_WIDTH       = BE_IDX_WIDTH + 1;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned OPSEL_WIDTH     = 9;
  localparam int unsigned VL_WIDTH        = 11;
  localparam int unsigned PIPE_DEPTH      = 6;
  localparam int unsigned SEW_WIDTH       = 2;
  localparam int unsigned START_IDX_WIDTH = 6;

  // opSel bit that marks a mask-producing compare
  localparam int unsigned OPSEL_MASK_BIT  = 8;

  typedef enum logic [SEW_WIDTH-1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vadd_tail_be.sv
// Byte enable for the final beat of an instruction: the low (rem << sew)
// bytes, or every byte when the element count fills the beat exactly.
module vadd_tail_be
  import vadd_issue_seq_pkg::*;
(
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [BE_IDX_WIDTH-1:0] rem,
  output logic [BE_WIDTH-1:0]     be
);

  localparam int unsigned NBYTES_WIDTH = BE_IDX_WIDTH + 1;

  logic [NBYTES_WIDTH-1:0] nbytes;

  assign nbytes = NBYTES_WIDTH'(rem) << sew;

  // Thermometer mask of the active bytes
  always_comb begin
    be = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      be[i] = (rem == '0) || (NBYTES_WIDTH'(i) < nbytes);
    end
  end

endmodule

// File: rtl/vadd_issue_seq.sv
// Sequences one vAdd-family instruction into per-beat VRF reads and
// ALU requests, then drains the fixed-latency pipeline and pulses done.
module vadd_issue_seq
  import vadd_issue_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OPSEL_WIDTH-1:0]     cmd_opSel,
  input  logic [SEW_WIDTH-1:0]       cmd_sew,
  input  logic [VL_WIDTH-1:0]        cmd_vl,
  input  logic [ADDR_WIDTH-1:0]      cmd_vs1,
  input  logic [ADDR_WIDTH-1:0]      cmd_vs2,
  input  logic [ADDR_WIDTH-1:0]      cmd_vd,
  input  logic                       cmd_avg,
  input  logic                       issue_stall,
  output logic                       vrf_rd_en,
  output logic [ADDR_WIDTH-1:0]      vrf_rd_addr0,
  output logic [ADDR_WIDTH-1:0]      vrf_rd_addr1,
  output logic                       alu_valid,
  output logic [SEW_WIDTH-1:0]       alu_sew,
  output logic [OPSEL_WIDTH-1:0]     alu_opSel,
  output logic                       alu_avg,
  output logic [ADDR_WIDTH-1:0]      alu_addr,
  output logic [BE_WIDTH-1:0]        alu_be,
  output logic [START_IDX_WIDTH-1:0] alu_start_idx,
  output logic                       alu_req_start,
  output logic                       alu_req_end,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CNT_WIDTH   = VL_WIDTH + 1;
  localparam int unsigned DRAIN_WIDTH = $clog2(PIPE_DEPTH + 1);
  localparam int unsigned SHIFT_WIDTH = 3;

  state_e                  state, state_d;
  logic [CNT_WIDTH-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0]    elem_q, elem_d;
  logic [CNT_WIDTH-1:0]    nbeats_q;
  logic [DRAIN_WIDTH-1:0]  drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]   rd_addr0_q, rd_addr0_d;
  logic [ADDR_WIDTH-1:0]   rd_addr1_q, rd_addr1_d;
  logic [ADDR_WIDTH-1:0]   vd_q;
  logic [SEW_WIDTH-1:0]    sew_q;
  logic [OPSEL_WIDTH-1:0]  opsel_q;
  logic                    avg_q;
  logic [BE_IDX_WIDTH-1:0] rem_q;
  logic [EPB_WIDTH-1:0]    epb_q;

  logic                    accept_c;
  logic                    rd_en_c;
  logic                    cmd_ready_d;
  logic                    busy_d;
  logic                    done_d;

  logic [EPB_WIDTH-1:0]       cmd_epb_c;
  logic [SHIFT_WIDTH-1:0]     cmd_shift_c;
  logic [CNT_WIDTH-1:0]       cmd_nbeats_c;
  logic [BE_IDX_WIDTH-1:0]    cmd_rem_c;
  logic                       last_beat_c;
  logic                       mask_op_c;
  logic [ADDR_WIDTH-1:0]      beat_addr_c;
  logic [START_IDX_WIDTH-1:0] beat_start_idx_c;
  logic [BE_WIDTH-1:0]        tail_be_c;

  // Per-command geometry: elements per beat, beat count and tail remainder
  assign cmd_epb_c    = EPB_WIDTH'(BE_WIDTH) >> cmd_sew;
  assign cmd_shift_c  = SHIFT_WIDTH'(BE_IDX_WIDTH) - SHIFT_WIDTH'(cmd_sew);
  assign cmd_nbeats_c = (CNT_WIDTH'(cmd_vl) + CNT_WIDTH'(cmd_epb_c) - CNT_WIDTH'(1)) >> cmd_shift_c;
  assign cmd_rem_c    = cmd_vl[BE_IDX_WIDTH-1:0] & BE_IDX_WIDTH'(cmd_epb_c - EPB_WIDTH'(1));

  // Per-beat ALU fields; mask ops address by packed mask bit position
  assign last_beat_c      = (beat_q == nbeats_q - CNT_WIDTH'(1));
  assign mask_op_c        = opsel_q[OPSEL_MASK_BIT];
  assign beat_addr_c      = mask_op_c ? (vd_q + ADDR_WIDTH'(elem_q >> START_IDX_WIDTH))
                                      : (vd_q + ADDR_WIDTH'(beat_q));
  assign beat_start_idx_c = mask_op_c ? elem_q[START_IDX_WIDTH-1:0] : '0;

  vadd_tail_be u_tail_be (
    .sew (sew_q),
    .rem (rem_q),
    .be  (tail_be_c)
  );

  // VRF read port is driven in the issue cycle itself (1-cycle read latency)
  assign vrf_rd_en    = rd_en_c;
  assign vrf_rd_addr0 = rd_addr0_q;
  assign vrf_rd_addr1 = rd_addr1_q;

  // Next-state, counters and read issue
  always_comb begin
    state_d    = state;
    beat_d     = beat_q;
    elem_d     = elem_q;
    drain_d    = drain_q;
    rd_addr0_d = rd_addr0_q;
    rd_addr1_d = rd_addr1_q;
    accept_c   = 1'b0;
    rd_en_c    = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c   = 1'b1;
          beat_d     = '0;
          elem_d     = '0;
          drain_d    = '0;
          rd_addr0_d = cmd_vs1;
          rd_addr1_d = cmd_vs2;
          state_d    = (cmd_vl == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (!issue_stall) begin
          rd_en_c    = 1'b1;
          beat_d     = beat_q + CNT_WIDTH'(1);
          elem_d     = elem_q + CNT_WIDTH'(epb_q);
          rd_addr0_d = rd_addr0_q + ADDR_WIDTH'(1);
          rd_addr1_d = rd_addr1_q + ADDR_WIDTH'(1);
          if (last_beat_c) begin
            state_d = DRAIN;
            drain_d = DRAIN_WIDTH'(PIPE_DEPTH);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q - DRAIN_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DRAIN) && (drain_d == '0);
  end

  // State, counters and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_q     <= '0;
      elem_q     <= '0;
      drain_q    <= '0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      beat_q     <= beat_d;
      elem_q     <= elem_d;
      drain_q    <= drain_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      cmd_ready  <= cmd_ready_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Capture command fields and derived geometry on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vd_q     <= '0;
      sew_q    <= '0;
      opsel_q  <= '0;
      avg_q    <= 1'b0;
      nbeats_q <= '0;
      rem_q    <= '0;
      epb_q    <= '0;
    end else if (accept_c) begin
      vd_q     <= cmd_vd;
      sew_q    <= cmd_sew;
      opsel_q  <= cmd_opSel;
      avg_q    <= cmd_avg;
      nbeats_q <= cmd_nbeats_c;
      rem_q    <= cmd_rem_c;
      epb_q    <= cmd_epb_c;
    end
  end

  // ALU request stage, aligned with VRF read data one cycle after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_valid     <= 1'b0;
      alu_req_start <= 1'b0;
      alu_req_end   <= 1'b0;
      alu_sew       <= '0;
      alu_opSel     <= '0;
      alu_avg       <= 1'b0;
      alu_addr      <= '0;
      alu_be        <= '0;
      alu_start_idx <= '0;
    end else begin
      alu_valid     <= rd_en_c;
      alu_req_start <= rd_en_c && (beat_q == '0);
      alu_req_end   <= rd_en_c && last_beat_c;
      if (rd_en_c) begin
        alu_sew       <= sew_q;
        alu_opSel     <= opsel_q;
        alu_avg       <= avg_q;
        alu_addr      <= beat_addr_c;
        alu_be        <= last_beat_c ? tail_be_c : '1;
        alu_start_idx <= beat_start_idx_c;
      end
    end
  end

endmodule
